// File: rtl/hilo_muldiv_unit.sv
// Execute-stage multiply/divide unit holding the HI/LO registers; restoring divider runs 32 cycles.
// Optional MDU_DIV0_FAST_EN: a zero divisor finishes in IDLE in one cycle. States: IDLE (accept requests), DIV (iterating).
module hilo_muldiv_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        START_E,
    input  logic        DIV_START_E,
    input  logic        SIGNED_E,
    input  logic        hi_lo_en_E,
    input  logic        hi_lo_reg_control_E,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic {IDLE, DIV} state_t;

    state_t      state;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic [4:0]  count;
    logic        quo_neg;
    logic        rem_neg;
    logic        div_zero;

    logic        sign_a;
    logic        sign_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] final_lo;
    logic [31:0] final_hi;
    logic        div0_fast;

    assign sign_a  = SIGNED_E & SrcAE[31];
    assign sign_b  = SIGNED_E & SrcBE[31];
    assign abs_a   = sign_a ? (32'd0 - SrcAE) : SrcAE;
    assign abs_b   = sign_b ? (32'd0 - SrcBE) : SrcBE;
    assign ext_a   = {{32{sign_a}}, SrcAE};
    assign ext_b   = {{32{sign_b}}, SrcBE};
    assign product = ext_a * ext_b;

    // The remainder stays below the divisor, so one 33-bit trial subtract is enough.
    assign shifted  = {rem, quo[31]};
    assign trial    = shifted - {1'b0, divisor};
    assign rem_next = trial[32] ? shifted[31:0] : trial[31:0];
    assign quo_next = {quo[30:0], ~trial[32]};
    assign final_lo = div_zero ? 32'hFFFF_FFFF : (quo_neg ? (32'd0 - quo_next) : quo_next);
    assign final_hi = rem_neg ? (32'd0 - rem_next) : rem_next;

`ifdef MDU_DIV0_FAST_EN
    assign div0_fast = (SrcBE == 32'd0);
`else
    assign div0_fast = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            HI       <= 32'd0;
            LO       <= 32'd0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            divisor  <= 32'd0;
            count    <= 5'd0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (DIV_START_E) begin
                        if (div0_fast) begin
                            HI   <= SrcAE;
                            LO   <= 32'hFFFF_FFFF;
                            DONE <= 1'b1;
                        end else begin
                            rem      <= 32'd0;
                            quo      <= abs_a;
                            divisor  <= abs_b;
                            quo_neg  <= sign_a ^ sign_b;
                            rem_neg  <= sign_a;
                            div_zero <= (SrcBE == 32'd0);
                            count    <= 5'd0;
                            state    <= DIV;
                            BUSY     <= 1'b1;
                        end
                    end else if (START_E) begin
                        HI <= product[63:32];
                        LO <= product[31:0];
                    end else if (hi_lo_en_E) begin
                        if (hi_lo_reg_control_E) HI <= SrcAE;
                        else                     LO <= SrcAE;
                    end
                end
                DIV: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        HI    <= final_hi;
                        LO    <= final_lo;
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed plus randomized checks of hilo_muldiv_unit against an arithmetic HI/LO model.
module tb_hilo_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] SrcAE, SrcBE;
    logic        START_E, DIV_START_E, SIGNED_E, hi_lo_en_E, hi_lo_reg_control_E;
    logic [31:0] HI, LO;
    logic        BUSY, DONE;

    int total  = 0;
    int passed = 0;
    logic [31:0] m_hi, m_lo;

`ifdef MDU_DIV0_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    hilo_muldiv_unit dut (
        .CLK(CLK), .RST(RST), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .START_E(START_E), .DIV_START_E(DIV_START_E), .SIGNED_E(SIGNED_E),
        .hi_lo_en_E(hi_lo_en_E), .hi_lo_reg_control_E(hi_lo_reg_control_E),
        .HI(HI), .LO(LO), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sp;
        logic [63:0] up;
        if (s) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return sp;
        end
        up = {32'd0, a} * {32'd0, b};
        return up;
    endfunction

    // Returns {HI, LO}: remainder and quotient with truncation toward zero.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, y, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clr_in();
        START_E = 0; DIV_START_E = 0; SIGNED_E = 0;
        hi_lo_en_E = 0; hi_lo_reg_control_E = 0;
        SrcAE = 32'd0; SrcBE = 32'd0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mul(input logic [31:0] a, input logic [31:0] b, input logic s, input logic with_move);
        SrcAE = a; SrcBE = b; SIGNED_E = s; START_E = 1;
        hi_lo_en_E = with_move; hi_lo_reg_control_E = 1;
        step();
        clr_in();
        {m_hi, m_lo} = ref_mul(a, b, s);
        chk("mul_hi", HI, m_hi);
        chk("mul_lo", LO, m_lo);
    endtask

    task automatic move(input logic [31:0] a, input logic to_hi);
        SrcAE = a; hi_lo_en_E = 1; hi_lo_reg_control_E = to_hi;
        step();
        clr_in();
        if (to_hi) m_hi = a;
        else       m_lo = a;
        chk("move_hi", HI, m_hi);
        chk("move_lo", LO, m_lo);
    endtask

    // inject: BUSY cycle at which stray requests are pulsed (-1 = none).
    task automatic div(input logic [31:0] a, input logic [31:0] b, input logic s, input int inject, input logic with_mul);
        int n;
        int exp_lat;
        SrcAE = a; SrcBE = b; SIGNED_E = s; DIV_START_E = 1; START_E = with_mul;
        step();
        clr_in();
        exp_lat = (b == 32'd0 && FAST) ? 0 : 32;
        chk("div_busy_rise", BUSY, (exp_lat != 0));
        if (BUSY) chk("div_hold", {HI, LO}, {m_hi, m_lo});
        n = BUSY ? 1 : 0;
        while (BUSY && n < 100) begin
            if (n == inject) begin
                START_E = 1; hi_lo_en_E = 1; hi_lo_reg_control_E = 1;
                SrcAE = $urandom; SrcBE = $urandom;
            end
            step();
            clr_in();
            if (BUSY) n++;
        end
        {m_hi, m_lo} = ref_div(a, b, s);
        chk("div_latency", n, exp_lat);
        chk("div_done", DONE, 1);
        chk("div_hi", HI, m_hi);
        chk("div_lo", LO, m_lo);
        step();
        chk("done_pulse_end", DONE, 0);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        clr_in();
        RST = 0;
        #2;
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        m_hi = 0; m_lo = 0;
        #10 RST = 1;
        step();

        mul(32'hFFFF_FFFE, 32'd3, 1, 0);
        mul(32'hFFFF_FFFE, 32'd3, 0, 0);
        div(32'hFFFF_FFF9, 32'd2, 1, -1, 0);
        div(32'd100, 32'd7, 0, -1, 0);
        div(32'h8000_0000, 32'hFFFF_FFFF, 1, -1, 0);
        div(32'd5, 32'd0, 0, -1, 0);
        div(32'hFFFF_FFF0, 32'd0, 1, -1, 0);
        move(32'h1234_5678, 1);
        move(32'h9ABC_DEF0, 0);
        mul(32'd7, 32'd9, 0, 1);
        div(32'hDEAD_BEEF, 32'h0000_1234, 1, 10, 0);
        div(32'd77, 32'd8, 0, -1, 1);

        // Reset in the middle of a divide.
        SrcAE = 32'h0001_2345; SrcBE = 32'd7; DIV_START_E = 1;
        step();
        clr_in();
        repeat (14) step();
        chk("mid_busy_before", BUSY, 1);
        RST = 0;
        #1;
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_hi", HI, 0);
        chk("mid_rst_lo", LO, 0);
        chk("mid_rst_done", DONE, 0);
        m_hi = 0; m_lo = 0;
        #1 RST = 1;
        seen = 0;
        repeat (40) begin
            step();
            if (DONE || BUSY) seen++;
        end
        chk("mid_rst_quiet", seen, 0);
        div(32'd9, 32'd3, 0, -1, 0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 4 == 1) rb = $urandom_range(0, 255);
            mul(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 10; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 3 == 0) rb = $urandom_range(1, 1000);
            if (i == 7) rb = 32'd0;
            div(ra, rb, 1'($urandom_range(0, 1)), (i == 4) ? 20 : -1, 0);
        end
        for (int i = 0; i < 4; i++) move($urandom, 1'(i % 2));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Execute-stage multiply/divide unit with the architectural HI/LO registers, consuming the multiply, divide and HI/LO-move controls registered by the decode/execute pipeline register. It performs single-cycle 32x32 multiplies, 32-cycle iterative restoring divides (signed and unsigned) and mthi/mtlo writes. It exports HI/LO to the execute result mux and a BUSY flag to the hazard unit for stalling.

## Interface
- No parameters.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- SrcAE  in  32  operand A (dividend / multiplicand / mthi-mtlo data), post-forwarding.
- SrcBE  in  32  operand B (divisor / multiplier), post-forwarding.
- START_E  in  1  multiply request.
- DIV_START_E  in  1  divide request.
- SIGNED_E  in  1  1 = signed (mult/div), 0 = unsigned (multu/divu).
- hi_lo_en_E  in  1  mthi/mtlo write request.
- hi_lo_reg_control_E  in  1  move target: 1 = HI, 0 = LO.
- HI  out  32  HI register (remainder / product[63:32]).
- LO  out  32  LO register (quotient / product[31:0]).
- BUSY  out  1  divide in progress; hazard unit stalls mfhi/mflo/mult/div/mthi/mtlo in ID.
- DONE  out  1  one-cycle pulse when a divide writes HI/LO.

## Operation
- States: IDLE, DIV. Reset: state IDLE, HI=0, LO=0, BUSY=0, DONE=0, iteration count 0, internal remainder/quotient/divisor 0.
- Requests are sampled only in IDLE. Priority when several are high: DIV_START_E > START_E > hi_lo_en_E. In DIV all requests are ignored (the hazard unit guarantees none are issued).
- Multiply (IDLE, START_E): {HI,LO} <= 64-bit product; signed uses two's-complement sign extension of both operands, unsigned uses zero extension. State stays IDLE.
- Move (IDLE, hi_lo_en_E): HI <= SrcAE if hi_lo_reg_control_E=1, else LO <= SrcAE. The other register is unchanged.
- Divide start (IDLE, DIV_START_E): latch |A| and |B| (raw operands when unsigned), quotient sign = A[31]^B[31] and remainder sign = A[31] (both 0 when unsigned), count <= 0, state <= DIV, BUSY <= 1.
- DIV iteration per cycle: shift {rem,quo} left by 1, trial = rem - divisor (33-bit), if non-negative rem <= trial and quo[0] <= 1. count increments.
- On the iteration with count==31: write LO = quotient and HI = remainder, each negated when its sign flag is set. Set state IDLE, BUSY <= 0, DONE <= 1 for one cycle.
- Divide by zero, final result in all modes: HI = original SrcAE, LO = 32'hFFFFFFFF. Latency is set by the configuration below.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (natural result of magnitude algorithm plus negation mod 2^32).
- Reset mid-divide: immediate return to IDLE with HI/LO cleared; no DONE pulse.
- HI/LO outputs hold their previous values throughout a divide.

## Timing
- Multiply and move: request sampled at edge E0; HI/LO valid after E0 (latency 1).
- Divide: start sampled at E0, BUSY high after E0. Iterations run at E1..E32. HI/LO are written and BUSY falls at E32. DONE is high in the cycle after E32.
- BUSY is high for exactly 32 cycles per divide. A new request is accepted on the edge at which BUSY is observed low (E33 at the earliest).
- BUSY and DONE are registered and carry no combinational path from the inputs.

## Configuration
- MDU_DIV0_FAST_EN defined: divisor 0 detected in IDLE completes in one cycle. HI/LO are written at E0, BUSY never rises, DONE pulses after E0.
- Not defined: divisor 0 runs the full 32-cycle sequence, and the final write is overridden with the divide-by-zero result. Timing is identical to a normal divide.

## Test plan
- Reset, then signed mult 0xFFFFFFFE x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA one cycle later; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- Signed div -7 / 2 -> BUSY high 32 cycles, DONE pulse, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/7 -> LO=14, HI=2.
- Div 0x80000000 / 0xFFFFFFFF signed -> LO=0x80000000, HI=0; divu 5/0 -> HI=5, LO=0xFFFFFFFF, latency 1 with MDU_DIV0_FAST_EN, 32 without.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 -> HI/LO updated independently; START_E and hi_lo_en_E together in IDLE -> multiply wins.
- DIV_START_E, then START_E/hi_lo_en_E pulsed at cycle 10 of the divide -> ignored; final HI/LO equal the divide result.
- Assert RST at cycle 15 of a divide -> BUSY=0, HI=LO=0, no DONE; a new divu 9/3 afterwards -> LO=3, HI=0.
